mem_req_arbiter: RTL and testbench

- Responder for the per-core memory request lines produced by decode and fetch.
- Accepts an instruction fetch (iREN) and a data load/store (dREN/dWEN) from one core.
- Serialises them onto a single-ported RAM interface with a valid/ready-style handshake.
- Returns iload/dload with single-cycle ihit/dhit pulses; sits between the datapath and the RAM/bus interface.

---
 rtl/mem_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serialises one core's instruction fetch and data load/store
// requests onto a single-ported RAM with a ready handshake, and returns
// single-cycle ihit/dhit completion pulses with the captured read data.
// Data requests win by default; a fetch is forced after STARVE_MAX data
// grants in a row while a fetch is waiting.
// Optional build macro: MEM_REQ_ARBITER_TIMEOUT_EN adds a RAM no-response
// timeout that completes the access with all-ones data and pulses err.
//
// state | meaning
// IDLE  | no access in flight; evaluate grants
// DATA  | data load/store presented on ram_*, waiting for ram_ready
// INSTR | instruction fetch presented on ram_*, waiting for ram_ready
// RESP  | ihit/dhit pulse cycle; no grant evaluated, return to IDLE

module mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          op_store;
  logic          op_instr;

  logic          dreq;
  logic          fetch_ok;
  logic          starved;
  logic          grant_d;
  logic          grant_i;

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  // Without the timeout the arbiter waits on the RAM forever and never errors.
  assign err = 1'b0;
`endif

  // Grant decision: data first unless a runnable fetch has been starved.
  always_comb begin
    dreq     = dREN | dWEN;
    fetch_ok = iREN & ~halt;
    starved  = (starve_cnt >= STARVE_LIM);
    grant_d  = dreq & (~starved | ~fetch_ok);
    grant_i  = fetch_ok & ~grant_d;
  end

  // Main FSM with registered RAM-side and core-side outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      op_store   <= 1'b0;
      op_instr   <= 1'b0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      iload      <= '0;
      dload      <= '0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
      tmo_cnt    <= '0;
      err        <= 1'b0;
`endif
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DATA;
            ram_addr  <= daddr;
            ram_wdata <= dstore;
            // A simultaneous dREN/dWEN is handled as a store.
            op_store  <= dWEN;
            op_instr  <= 1'b0;
            ram_wen   <= dWEN;
            ram_ren   <= ~dWEN;
            if (fetch_ok) begin
              if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
            end else if (!iREN) begin
              starve_cnt <= '0;
            end
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else if (grant_i) begin
            state      <= INSTR;
            ram_addr   <= iaddr;
            op_store   <= 1'b0;
            op_instr   <= 1'b1;
            ram_ren    <= 1'b1;
            ram_wen    <= 1'b0;
            starve_cnt <= '0;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end

        DATA, INSTR: begin
          if (ram_ready) begin
            state   <= RESP;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (op_instr) begin
              ihit  <= 1'b1;
              iload <= ram_rdata;
            end else begin
              dhit  <= 1'b1;
              if (!op_store) dload <= ram_rdata;
            end
          end
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // RAM never answered: drop the access, return all-ones, flag err.
            state   <= RESP;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            err     <= 1'b1;
            if (op_instr) begin
              ihit  <= 1'b1;
              iload <= '1;
            end else begin
              dhit  <= 1'b1;
              if (!op_store) dload <= '1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          ram_ren <= 1'b0;
          ram_wen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: RAM model with programmable wait,
// per-port expected-data queues popped on each hit, and per-scenario tasks
// with cycle-accurate inline checks.

module tb_mem_req_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ram_ren, ram_wen, err;
  logic [31:0] iload, dload, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'hBAD0_BAD0;
  logic        ram_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] last_dload;
  logic [31:0] mon_exp;
  int  ram_wait  = 0;
  bit  ram_hold  = 1'b0;
  int  busy_cnt  = 0;
  int  ihit_cnt  = 0;
  int  dhit_cnt  = 0;

  always #5 CLK = ~CLK;

  mem_req_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .err(err)
  );

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0010_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM: answers after ram_wait busy cycles unless held off.
  always @(posedge CLK) begin
    #1;
    if ((ram_ren || ram_wen) && !RST) begin
      if (!ram_hold && busy_cnt == ram_wait) begin
        ram_ready = 1'b1;
        ram_rdata = ram_model(ram_addr);
      end else begin
        ram_ready = 1'b0;
        ram_rdata = 32'hBAD0_BAD0;
      end
      busy_cnt++;
    end else begin
      ram_ready = 1'b0;
      ram_rdata = 32'hBAD0_BAD0;
      busy_cnt  = 0;
    end
  end

  // Scoreboard: every hit must match the oldest expectation of its port.
  always @(negedge CLK) begin
    if (!RST && (ihit || dhit)) begin
      n_checks++;
      if (ihit && dhit) begin
        n_fail++;
        $display("FAIL hit_exclusive: ihit=%0b dhit=%0b, required only one", ihit, dhit);
      end
      if (ihit) begin
        ihit_cnt++;
        if (iq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_ihit: unexpected ihit with iload=%h", iload);
        end else begin
          mon_exp = iq.pop_front();
          if (iload !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_iload: got %h, required %h", iload, mon_exp);
          end
        end
      end
      if (dhit) begin
        dhit_cnt++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_dhit: unexpected dhit with dload=%h", dload);
        end else begin
          mon_exp = dq.pop_front();
          if (dload !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_dload: got %h, required %h", dload, mon_exp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_hold = 1'b0; ram_wait = 0;
    iq.delete(); dq.delete();
    last_dload = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    last_dload = '0;
    #1;
    n_checks++;
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ihit=%b dhit=%b iload=%h dload=%h ren=%b wen=%b addr=%h wdata=%h err=%b, required all 0",
               ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err);
    end
    do_reset();
    @(negedge CLK);
    n_checks++;
    if ({ihit, dhit, ram_ren, ram_wen, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ihit=%b dhit=%b ren=%b wen=%b err=%b, required 0", ihit, dhit, ram_ren, ram_wen, err);
    end
  endtask

  task automatic test_reset_mid_data();
    int d0;
    bit idle_ok;
    ram_hold = 1'b1;
    dREN = 1'b1; daddr = 32'h0000_0080;
    @(negedge CLK);
    n_checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL mid_data_busy: ren=%b addr=%h, required 1/00000080", ram_ren, ram_addr);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ren=%b addr=%h dhit=%b dload=%h, required all 0", ram_ren, ram_addr, dhit, dload);
    end
    dREN = 1'b0; ram_hold = 1'b0;
    d0 = dhit_cnt;
    @(negedge CLK);
    RST = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (ram_ren || ram_wen || dhit) idle_ok = 1'b0;
    end
    n_checks++;
    if (!idle_ok || dhit_cnt != d0) begin
      n_fail++;
      $display("FAIL abandoned_access: idle_ok=%0b dhits=%0d, required 1/%0d", idle_ok, dhit_cnt, d0);
    end
  endtask

  task automatic test_single_fetch();
    ram_wait = 0;
    iREN = 1'b1; iaddr = 32'h0000_0040;
    iq.push_back(32'h0010_0093);
    @(negedge CLK);
    n_checks++;
    if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h40 || ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c1: ren=%b wen=%b addr=%h ihit=%b, required 1/0/00000040/0", ram_ren, ram_wen, ram_addr, ihit);
    end
    @(negedge CLK);
    n_checks++;
    if (ihit !== 1'b1 || iload !== 32'h0010_0093 || ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c2: ihit=%b iload=%h ren=%b, required 1/00100093/0", ihit, iload, ram_ren);
    end
    iREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ihit !== 1'b0 || iload !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL fetch_c3: ihit=%b iload=%h, required 0/00100093", ihit, iload);
    end
  endtask

  task automatic test_simultaneous();
    ram_wait = 0;
    iREN = 1'b1; iaddr = 32'h0000_0044;
    dREN = 1'b1; daddr = 32'h0000_0300;
    iq.push_back(ram_model(32'h44));
    dq.push_back(ram_model(32'h300));
    last_dload = ram_model(32'h300);
    @(negedge CLK);
    n_checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL simul_c1: ren=%b addr=%h, required 1/00000300", ram_ren, ram_addr);
    end
    @(negedge CLK);
    n_checks++;
    if (dhit !== 1'b1 || ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_c2: dhit=%b ihit=%b, required 1/0", dhit, ihit);
    end
    dREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ram_ren !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_c3: ren=%b ihit=%b dhit=%b, required 0/0/0", ram_ren, ihit, dhit);
    end
    @(negedge CLK);
    n_checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL simul_c4: ren=%b addr=%h, required 1/00000044", ram_ren, ram_addr);
    end
    @(negedge CLK);
    n_checks++;
    if (ihit !== 1'b1 || iload !== ram_model(32'h44)) begin
      n_fail++;
      $display("FAIL simul_c5: ihit=%b iload=%h, required 1/%h", ihit, iload, ram_model(32'h44));
    end
    iREN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_store_wait();
    logic [31:0] prev;
    prev = last_dload;
    ram_wait = 2;
    dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
    dq.push_back(prev);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h100 || ram_wdata !== 32'hDEAD_BEEF || dhit !== 1'b0) begin
        n_fail++;
        $display("FAIL store_c%0d: wen=%b ren=%b addr=%h wdata=%h dhit=%b, required 1/0/00000100/deadbeef/0",
                 c, ram_wen, ram_ren, ram_addr, ram_wdata, dhit);
      end
      if (c == 1) begin
        daddr  = 32'h0000_0200;
        dstore = 32'h1234_5678;
      end
    end
    @(negedge CLK);
    n_checks++;
    if (dhit !== 1'b1 || dload !== prev || ram_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL store_c4: dhit=%b dload=%h wen=%b, required 1/%h/0", dhit, dload, ram_wen, prev);
    end
    dWEN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL store_c5: dhit=%b, required 0", dhit);
    end
    ram_wait = 0;
  endtask

  task automatic test_starvation();
    string seq;
    int    hits;
    int    cyc;
    do_reset();
    ram_wait = 1;
    seq = "";
    hits = 0;
    cyc = 0;
    iREN = 1'b1; iaddr = 32'h0000_1000;
    iq.push_back(ram_model(iaddr));
    dREN = 1'b1; daddr = 32'h0000_2000;
    dq.push_back(ram_model(daddr));
    while (hits < 10 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (dhit) begin
        seq = {seq, "D"};
        hits++;
        daddr = daddr + 32'd4;
        dq.push_back(ram_model(daddr));
      end
      if (ihit) begin
        seq = {seq, "I"};
        hits++;
        iaddr = iaddr + 32'd4;
        iq.push_back(ram_model(iaddr));
      end
    end
    iREN = 1'b0; dREN = 1'b0;
    n_checks++;
    if (seq != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL starve_order: got %s after %0d cycles, required DDDDIDDDDI", seq, cyc);
    end
    do_reset();
  endtask

  task automatic test_halt();
    int i0, d0, cyc;
    do_reset();
    halt = 1'b1;
    iREN = 1'b1; iaddr = 32'h0000_3000;
    dREN = 1'b1; daddr = 32'h0000_4000;
    dq.push_back(ram_model(daddr));
    i0 = ihit_cnt; d0 = dhit_cnt; cyc = 0;
    while ((dhit_cnt - d0) < 8 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (dhit) begin
        daddr = daddr + 32'd4;
        dq.push_back(ram_model(daddr));
      end
    end
    n_checks++;
    if ((dhit_cnt - d0) != 8) begin
      n_fail++;
      $display("FAIL halt_data: %0d dhits in %0d cycles, required 8", dhit_cnt - d0, cyc);
    end
    n_checks++;
    if (ihit_cnt != i0) begin
      n_fail++;
      $display("FAIL halt_fetch: %0d ihits while halted, required 0", ihit_cnt - i0);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    ram_hold = 1'b1;
    dREN = 1'b1; daddr = 32'h0000_0500;
    ok = 1'b1;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
    dq.push_back(32'hFFFF_FFFF);
    for (int c = 1; c <= 64; c++) begin
      @(negedge CLK);
      if (ram_ren !== 1'b1 || err !== 1'b0 || dhit !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_wait: ren not held 64 cycles or early err/dhit (ok=%0b), required 1", ok);
    end
    @(negedge CLK);
    n_checks++;
    if (dhit !== 1'b1 || err !== 1'b1 || dload !== 32'hFFFF_FFFF || ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: dhit=%b err=%b dload=%h ren=%b, required 1/1/ffffffff/0", dhit, err, dload, ram_ren);
    end
    dREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (err !== 1'b0 || dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: err=%b dhit=%b, required 0/0", err, dhit);
    end
`else
    for (int c = 1; c <= 80; c++) begin
      @(negedge CLK);
      if (ram_ren !== 1'b1 || err !== 1'b0 || dhit !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL no_timeout: ren dropped or err/dhit seen (ok=%0b), required 1", ok);
    end
    n_checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL no_timeout_hold: ren=%b addr=%h, required 1/00000500", ram_ren, ram_addr);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_reset_mid_data();
    test_single_fetch();
    test_simultaneous();
    test_store_wait();
    test_starvation();
    test_halt();
    test_timeout();
    n_checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d fetch / %0d data expectations left, required 0/0", iq.size(), dq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
